l1state_ctl: RTL and testbench

Controller for the L1 MESI state array. It sits between the MM pipeline, the fill path and the array's single write port and single read port. After reset it invalidates every entry. It arbitrates per-way state writes between pipeline upgrades, fills and an optional flush walker. It also stalls pipeline reads that would miss a write in flight to the same set.

---
 rtl/l1state_ctl.sv | 140 ++++++++++++++
 tb/tb_l1state_ctl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1state_ctl.sv
// l1state_ctl: L1 MESI state-array controller. It runs the post-reset invalidate walk, arbitrates writes and stalls hazardous reads.
// Optional build macro L1STATE_FLUSH_EN adds the flush_req invalidate-all walk (FLUSH state, flush_done pulse).
package l1state_pkg;
  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } t_mesi;
  localparam int L1_NUM_SETS = 64;
  localparam int L1_NUM_WAYS = 8;
endpackage

module l1state_ctl
  import l1state_pkg::*;
#(
  parameter int NUM_SETS = L1_NUM_SETS,
  parameter int NUM_WAYS = L1_NUM_WAYS,
  localparam int SW = $clog2(NUM_SETS),
  localparam int WW = $clog2(NUM_WAYS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req,
  input  logic [SW-1:0] rd_set,
  output logic          rd_gnt,
  input  logic          pwr_req,
  input  logic [SW-1:0] pwr_set,
  input  logic [WW-1:0] pwr_way,
  input  t_mesi         pwr_state,
  input  logic          fill_req,
  input  logic [SW-1:0] fill_set,
  input  logic [WW-1:0] fill_way,
  input  t_mesi         fill_state,
  output logic          fill_gnt,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          ready,
  output logic          state_rd_en_mm1,
  output logic [SW-1:0] set_addr_mm1,
  output logic          state_wr_en_mm3,
  output logic [SW-1:0] set_addr_mm3,
  output logic [WW-1:0] state_wr_way_mm3,
  output t_mesi         state_wr_state_mm3
);

  localparam int IW = SW + WW;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} t_state;

  t_state        state, state_nxt;
  logic [IW-1:0] widx;
  logic          walk_act, walk_gnt, walk_last, hazard, go_flush;

  // Grants are gated by reset so every output sits at its reset value while reset is high.
  assign ready     = !reset && (state == ST_IDLE);
  assign walk_act  = !reset && (state == ST_INIT || state == ST_FLUSH);
  assign walk_gnt  = walk_act && !pwr_req;
  assign walk_last = (widx == {IW{1'b1}});
  assign fill_gnt  = fill_req && ready && !pwr_req;

  assign hazard          = state_wr_en_mm3 && (set_addr_mm3 == rd_set);
  assign rd_gnt          = rd_req && ready && !hazard;
  assign state_rd_en_mm1 = rd_gnt;
  assign set_addr_mm1    = rd_set;

`ifdef L1STATE_FLUSH_EN
  logic flush_pend, done_q;

  // A flush requested while the init walk is still running is remembered until IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_pend <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == ST_FLUSH) && walk_gnt && walk_last;
      if (state == ST_INIT && flush_req)
        flush_pend <= 1'b1;
      else if (state == ST_IDLE)
        flush_pend <= 1'b0;
    end
  end

  assign go_flush   = flush_req || flush_pend;
  assign flush_done = done_q;
`else
  logic unused_flush;
  assign unused_flush = flush_req;
  assign go_flush     = 1'b0;
  assign flush_done   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (walk_gnt && walk_last) state_nxt = ST_IDLE;
      ST_IDLE:  if (go_flush) state_nxt = ST_FLUSH;
      ST_FLUSH: if (walk_gnt && walk_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Stage boundary: the granted write (pwr > walker > fill) is registered onto the mm3 port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_INIT;
      widx               <= '0;
      state_wr_en_mm3    <= 1'b0;
      set_addr_mm3       <= '0;
      state_wr_way_mm3   <= '0;
      state_wr_state_mm3 <= MESI_I;
    end else begin
      state           <= state_nxt;
      state_wr_en_mm3 <= pwr_req || walk_gnt || fill_gnt;
      if (walk_gnt)
        widx <= widx + IW'(1);
      if (pwr_req) begin
        set_addr_mm3       <= pwr_set;
        state_wr_way_mm3   <= pwr_way;
        state_wr_state_mm3 <= pwr_state;
      end else if (walk_gnt) begin
        set_addr_mm3       <= widx[IW-1:WW];
        state_wr_way_mm3   <= widx[WW-1:0];
        state_wr_state_mm3 <= MESI_I;
      end else if (fill_gnt) begin
        set_addr_mm3       <= fill_set;
        state_wr_way_mm3   <= fill_way;
        state_wr_state_mm3 <= fill_state;
      end
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(state == ST_INIT && pwr_req)) else $error("pwr_req asserted during INIT");
  end
`endif

endmodule

// File: tb/tb_l1state_ctl.sv
// Self-checking bench for l1state_ctl (NUM_SETS=64, NUM_WAYS=8); flush scenarios run when L1STATE_FLUSH_EN is defined.
module tb_l1state_ctl;
  import l1state_pkg::*;

  localparam int NS = 64;
  localparam int NW = 8;
  localparam int SW = 6;
  localparam int WW = 3;
  localparam int NE = NS * NW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_req = 1'b0;
  logic [SW-1:0] rd_set = '0;
  logic          rd_gnt;
  logic          pwr_req = 1'b0;
  logic [SW-1:0] pwr_set = '0;
  logic [WW-1:0] pwr_way = '0;
  t_mesi         pwr_state = MESI_I;
  logic          fill_req = 1'b0;
  logic [SW-1:0] fill_set = '0;
  logic [WW-1:0] fill_way = '0;
  t_mesi         fill_state = MESI_I;
  logic          fill_gnt;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          ready;
  logic          state_rd_en_mm1;
  logic [SW-1:0] set_addr_mm1;
  logic          state_wr_en_mm3;
  logic [SW-1:0] set_addr_mm3;
  logic [WW-1:0] state_wr_way_mm3;
  t_mesi         state_wr_state_mm3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  l1state_ctl #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_set(rd_set), .rd_gnt(rd_gnt),
    .pwr_req(pwr_req), .pwr_set(pwr_set), .pwr_way(pwr_way), .pwr_state(pwr_state),
    .fill_req(fill_req), .fill_set(fill_set), .fill_way(fill_way), .fill_state(fill_state),
    .fill_gnt(fill_gnt), .flush_req(flush_req), .flush_done(flush_done), .ready(ready),
    .state_rd_en_mm1(state_rd_en_mm1), .set_addr_mm1(set_addr_mm1),
    .state_wr_en_mm3(state_wr_en_mm3), .set_addr_mm3(set_addr_mm3),
    .state_wr_way_mm3(state_wr_way_mm3), .state_wr_state_mm3(state_wr_state_mm3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req = 1'b0; rd_set = '0;
    pwr_req = 1'b0; pwr_set = '0; pwr_way = '0; pwr_state = MESI_I;
    fill_req = 1'b0; fill_set = '0; fill_way = '0; fill_state = MESI_I;
    flush_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    rd_req = 1'b1; fill_req = 1'b1; fill_set = 6'd3;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_rd_gnt: got %b want 0", rd_gnt); end
    checks++; if (fill_gnt !== 1'b0) begin errors++; $display("FAIL reset_fill_gnt: got %b want 0", fill_gnt); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    checks++; if (state_rd_en_mm1 !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", state_rd_en_mm1); end
    checks++; if (state_wr_en_mm3 !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", state_wr_en_mm3); end
    checks++; if (set_addr_mm3 !== 6'd0 || state_wr_way_mm3 !== 3'd0 || set_addr_mm1 !== 6'd0) begin
      errors++; $display("FAIL reset_addr: got set3=%0d way3=%0d set1=%0d want 0/0/0", set_addr_mm3, state_wr_way_mm3, set_addr_mm1);
    end
    checks++; if (state_wr_state_mm3 !== MESI_I) begin errors++; $display("FAIL reset_wr_state: got %0d want %0d", state_wr_state_mm3, MESI_I); end
    tick();
    reset = 1'b0;
    clear_inputs();
  endtask

  // Entered at the start of cycle 1 after reset release; walker write k must show on mm3 in cycle k+2.
  task automatic do_init_sweep();
    int k;
    for (int c = 1; c <= NE + 1; c++) begin
      if (c <= NE) begin
        rd_req = 1'($urandom_range(0, 1)); rd_set = SW'($urandom_range(0, NS - 1));
        fill_req = 1'($urandom_range(0, 1)); fill_set = SW'($urandom_range(0, NS - 1));
        fill_way = WW'($urandom_range(0, NW - 1)); fill_state = t_mesi'($urandom_range(0, 3));
      end else begin
        clear_inputs();
      end
      @(negedge clk);
      checks++; if (ready !== (c == NE + 1)) begin errors++; $display("FAIL init_ready c=%0d: got %b want %b", c, ready, (c == NE + 1)); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL init_flush_done c=%0d: got %b want 0", c, flush_done); end
      if (c <= NE) begin
        checks++; if (rd_gnt !== 1'b0 || fill_gnt !== 1'b0) begin
          errors++; $display("FAIL init_no_gnt c=%0d: got rd=%b fill=%b want 0/0", c, rd_gnt, fill_gnt);
        end
      end
      if (c == 1) begin
        checks++; if (state_wr_en_mm3 !== 1'b0) begin errors++; $display("FAIL init_first_wr_en: got %b want 0", state_wr_en_mm3); end
      end else begin
        k = c - 2;
        checks++;
        if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== SW'(k / NW) || state_wr_way_mm3 !== WW'(k % NW) || state_wr_state_mm3 !== MESI_I) begin
          errors++;
          $display("FAIL init_walk k=%0d: got en=%b set=%0d way=%0d st=%0d want 1/%0d/%0d/%0d",
                   k, state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, k / NW, k % NW, MESI_I);
        end
      end
      tick();
    end
  endtask

  task automatic test_init_sweep();
    do_init_sweep();
  endtask

  task automatic test_random_idle();
    logic          e_en, e_rd, e_fill;
    logic [SW-1:0] e_set;
    logic [WW-1:0] e_way;
    t_mesi         e_st;
    clear_inputs();
    tick();
    e_en = 1'b0; e_set = '0; e_way = '0; e_st = MESI_I;
    for (int i = 0; i < 300; i++) begin
      pwr_req = ($urandom_range(0, 3) == 0);
      pwr_set = SW'($urandom_range(0, 3)); pwr_way = WW'($urandom_range(0, NW - 1));
      pwr_state = t_mesi'($urandom_range(0, 3));
      fill_req = 1'($urandom_range(0, 1));
      fill_set = SW'($urandom_range(0, 3)); fill_way = WW'($urandom_range(0, NW - 1));
      fill_state = t_mesi'($urandom_range(0, 3));
      rd_req = 1'($urandom_range(0, 1)); rd_set = SW'($urandom_range(0, 3));
      e_fill = fill_req && !pwr_req;
      e_rd   = rd_req && !(e_en && e_set == rd_set);
      @(negedge clk);
      checks++; if (state_wr_en_mm3 !== e_en) begin errors++; $display("FAIL rand_wr_en i=%0d: got %b want %b", i, state_wr_en_mm3, e_en); end
      if (e_en) begin
        checks++;
        if (set_addr_mm3 !== e_set || state_wr_way_mm3 !== e_way || state_wr_state_mm3 !== e_st) begin
          errors++;
          $display("FAIL rand_wr_data i=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                   i, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, e_set, e_way, e_st);
        end
      end
      checks++; if (rd_gnt !== e_rd || state_rd_en_mm1 !== e_rd) begin
        errors++; $display("FAIL rand_rd_gnt i=%0d: got gnt=%b en=%b want %b", i, rd_gnt, state_rd_en_mm1, e_rd);
      end
      checks++; if (set_addr_mm1 !== rd_set) begin errors++; $display("FAIL rand_rd_set i=%0d: got %0d want %0d", i, set_addr_mm1, rd_set); end
      checks++; if (fill_gnt !== e_fill) begin errors++; $display("FAIL rand_fill_gnt i=%0d: got %b want %b", i, fill_gnt, e_fill); end
      checks++; if (ready !== 1'b1 || flush_done !== 1'b0) begin
        errors++; $display("FAIL rand_ctl i=%0d: got ready=%b done=%b want 1/0", i, ready, flush_done);
      end
      if (pwr_req) begin
        e_en = 1'b1; e_set = pwr_set; e_way = pwr_way; e_st = pwr_state;
      end else if (fill_req) begin
        e_en = 1'b1; e_set = fill_set; e_way = fill_way; e_st = fill_state;
      end else begin
        e_en = 1'b0;
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_fill_vs_pipe();
    clear_inputs();
    tick();
    fill_req = 1'b1; fill_set = 6'd12; fill_way = 3'd5; fill_state = MESI_S;
    pwr_req = 1'b1; pwr_set = 6'd7; pwr_way = 3'd2; pwr_state = MESI_E;
    @(negedge clk);
    checks++; if (fill_gnt !== 1'b0) begin errors++; $display("FAIL fvp_c1_fill_gnt: got %b want 0", fill_gnt); end
    tick();
    pwr_set = 6'd8; pwr_way = 3'd1; pwr_state = MESI_M;
    @(negedge clk);
    checks++; if (fill_gnt !== 1'b0) begin errors++; $display("FAIL fvp_c2_fill_gnt: got %b want 0", fill_gnt); end
    checks++; if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== 6'd7 || state_wr_way_mm3 !== 3'd2 || state_wr_state_mm3 !== MESI_E) begin
      errors++; $display("FAIL fvp_c2_wr: got %b %0d/%0d/%0d want 1 7/2/%0d", state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, MESI_E);
    end
    tick();
    pwr_req = 1'b0;
    @(negedge clk);
    checks++; if (fill_gnt !== 1'b1) begin errors++; $display("FAIL fvp_c3_fill_gnt: got %b want 1", fill_gnt); end
    checks++; if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== 6'd8 || state_wr_way_mm3 !== 3'd1 || state_wr_state_mm3 !== MESI_M) begin
      errors++; $display("FAIL fvp_c3_wr: got %b %0d/%0d/%0d want 1 8/1/%0d", state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, MESI_M);
    end
    tick();
    fill_req = 1'b0;
    @(negedge clk);
    checks++; if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== 6'd12 || state_wr_way_mm3 !== 3'd5 || state_wr_state_mm3 !== MESI_S) begin
      errors++; $display("FAIL fvp_c4_wr: got %b %0d/%0d/%0d want 1 12/5/%0d", state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, MESI_S);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_read_hazard();
    for (int v = 0; v < 2; v++) begin
      clear_inputs();
      tick();
      fill_req = 1'b1; fill_set = 6'd9; fill_way = 3'd4; fill_state = MESI_E;
      @(negedge clk);
      checks++; if (fill_gnt !== 1'b1) begin errors++; $display("FAIL hz_fill_gnt v=%0d: got %b want 1", v, fill_gnt); end
      tick();
      fill_req = 1'b0; rd_req = 1'b1; rd_set = (v == 0) ? 6'd9 : 6'd10;
      @(negedge clk);
      checks++; if (rd_gnt !== (v == 1) || state_rd_en_mm1 !== (v == 1)) begin
        errors++; $display("FAIL hz_n1 v=%0d: got gnt=%b en=%b want %b", v, rd_gnt, state_rd_en_mm1, (v == 1));
      end
      checks++; if (set_addr_mm1 !== rd_set) begin errors++; $display("FAIL hz_n1_set v=%0d: got %0d want %0d", v, set_addr_mm1, rd_set); end
      tick();
      rd_set = 6'd9;
      @(negedge clk);
      checks++; if (rd_gnt !== 1'b1) begin errors++; $display("FAIL hz_n2 v=%0d: got %b want 1", v, rd_gnt); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    tick();
    for (int i = 0; i <= 4; i++) begin
      fill_req = (i < 4); fill_set = SW'(20 + i); fill_way = WW'(i); fill_state = MESI_S;
      rd_req = 1'b1; rd_set = 6'd40;
      @(negedge clk);
      checks++; if (fill_gnt !== (i < 4) || rd_gnt !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt i=%0d: got fill=%b rd=%b want %b/1", i, fill_gnt, rd_gnt, (i < 4));
      end
      if (i > 0) begin
        checks++; if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== SW'(19 + i) || state_wr_way_mm3 !== WW'(i - 1)) begin
          errors++; $display("FAIL b2b_wr i=%0d: got %b %0d/%0d want 1 %0d/%0d", i, state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, 19 + i, i - 1);
        end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

`ifdef L1STATE_FLUSH_EN
  // Walker preempted at index pidx: flush cycle pidx+1 carries the pipe write to (5,3,M).
  task automatic test_flush_preempt(input int pidx, input bit expect_m);
    t_mesi sh [NE];
    int    flen, ndone, done_k, j, w, others;
    for (int e = 0; e < NE; e++) sh[e] = MESI_E;
    flen = 0; ndone = 0; done_k = -1;
    clear_inputs();
    tick();
    flush_req = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL fl_start_ready: got %b want 1", ready); end
    tick();
    flush_req = 1'b0;
    for (int k = 1; k <= NE + 3; k++) begin
      pwr_req = (k == pidx + 1); pwr_set = 6'd5; pwr_way = 3'd3; pwr_state = MESI_M;
      @(negedge clk);
      if (ready === 1'b0) flen++;
      if (flush_done === 1'b1) begin ndone++; done_k = k; end
      if (state_wr_en_mm3 === 1'b1) sh[int'(set_addr_mm3) * NW + int'(state_wr_way_mm3)] = state_wr_state_mm3;
      j = k - 1;
      if (j >= 1 && j <= NE + 1) begin
        checks++;
        if (j == pidx + 1) begin
          if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== 6'd5 || state_wr_way_mm3 !== 3'd3 || state_wr_state_mm3 !== MESI_M) begin
            errors++; $display("FAIL fl_pwr p=%0d: got %b %0d/%0d/%0d want 1 5/3/%0d", pidx, state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, MESI_M);
          end
        end else begin
          w = (j <= pidx) ? j - 1 : j - 2;
          if (state_wr_en_mm3 !== 1'b1 || set_addr_mm3 !== SW'(w / NW) || state_wr_way_mm3 !== WW'(w % NW) || state_wr_state_mm3 !== MESI_I) begin
            errors++; $display("FAIL fl_walk p=%0d w=%0d: got %b %0d/%0d/%0d want 1 %0d/%0d/0", pidx, w, state_wr_en_mm3, set_addr_mm3, state_wr_way_mm3, state_wr_state_mm3, w / NW, w % NW);
          end
        end
      end
      tick();
    end
    clear_inputs();
    checks++; if (flen != NE + 1) begin errors++; $display("FAIL fl_len p=%0d: got %0d want %0d", pidx, flen, NE + 1); end
    checks++; if (ndone != 1 || done_k != NE + 2) begin errors++; $display("FAIL fl_done p=%0d: got n=%0d at %0d want 1 at %0d", pidx, ndone, done_k, NE + 2); end
    checks++; if (sh[5 * NW + 3] !== (expect_m ? MESI_M : MESI_I)) begin
      errors++; $display("FAIL fl_entry53 p=%0d: got %0d want %0d", pidx, sh[5 * NW + 3], expect_m ? MESI_M : MESI_I);
    end
    others = 0;
    for (int e = 0; e < NE; e++) if (e != 5 * NW + 3 && sh[e] !== MESI_I) others++;
    checks++; if (others != 0) begin errors++; $display("FAIL fl_others p=%0d: got %0d non-I entries want 0", pidx, others); end
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int k = 1; k <= 200; k++) tick();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (flush_done !== 1'b0 || ready !== 1'b0) begin
      errors++; $display("FAIL rmf_ctl: got done=%b ready=%b want 0/0", flush_done, ready);
    end
    tick();
    reset = 1'b0;
    do_init_sweep();
  endtask
`else
  task automatic test_flush_ignored();
    clear_inputs();
    tick();
    flush_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if (state_wr_en_mm3 !== 1'b0 || ready !== 1'b1 || flush_done !== 1'b0) begin
        errors++; $display("FAIL noflush i=%0d: got wr=%b ready=%b done=%b want 0/1/0", i, state_wr_en_mm3, ready, flush_done);
      end
      tick();
    end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_init_sweep();
    test_random_idle();
    test_fill_vs_pipe();
    test_read_hazard();
    test_back_to_back();
`ifdef L1STATE_FLUSH_EN
    test_flush_preempt(41, 1'b0);
    test_flush_preempt(48, 1'b1);
    test_reset_mid_flush();
`else
    test_flush_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
